// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: buffers tagged audio subframes from a stream
// interface in a small FIFO and shifts them out as a 64-SCLK I2S frame
// (32 SCLK per channel slot, MSB first, one-bit delay after word select).
module i2s_tx_serializer #(
  parameter int AUD_WIDTH             = 24,
  parameter int AXI_STREAM_DATA_WIDTH = 32,
  parameter int AXI_STREAM_TID_WIDTH  = 3,
  parameter int FIFO_DEPTH            = 4
) (
  input  logic                             aud_mclk,
  input  logic                             aud_mresetn,
  input  logic                             enable,
  input  logic [7:0]                       sclk_div,
  input  logic [AXI_STREAM_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXI_STREAM_TID_WIDTH-1:0]  s_axis_tid,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  output logic                             sclk_out,
  output logic                             lrclk_out,
  output logic                             sdata_out,
  output logic                             underflow,
  output logic                             chan_err,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_LEVEL   = LW'(FIFO_DEPTH);
  localparam logic [5:0]    LAST_DATA_POS = 6'(AUD_WIDTH);

  // FIFO storage: each entry is {channel, sample}
  logic [AUD_WIDTH:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [AUD_WIDTH:0] fifo_head;

  logic               enable_d;
  logic               running;
  logic [7:0]         div_reg;
  logic [7:0]         div_cnt;
  logic               div_tc;
  logic               sclk_fall;
  logic [5:0]         bit_cnt;
  logic [5:0]         bit_cnt_nxt;
  logic               slot_start;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               head_chan_ok;
  logic [AUD_WIDTH-1:0] shift_reg;
  logic               unused_bits;

  // Only the sample field and the channel bit of the stream are meaningful
  assign unused_bits = ^{s_axis_tdata[AXI_STREAM_DATA_WIDTH-1:AUD_WIDTH+4],
                         s_axis_tdata[3:0],
                         s_axis_tid[AXI_STREAM_TID_WIDTH-1:1]};

  // The divider only counts once the enable rising edge has been seen and
  // the divisor captured, so the first SCLK rise lands div cycles later
  assign running      = enable && enable_d;
  assign s_axis_tready = enable && aud_mresetn && (fifo_level < DEPTH_LEVEL);
  assign push         = s_axis_tvalid && s_axis_tready;
  assign fifo_empty   = (fifo_level == '0);
  assign fifo_head    = fifo_mem[rd_ptr];
  assign div_tc       = running && (div_cnt == (div_reg - 8'd1));
  assign sclk_fall    = div_tc && sclk_out;
  assign bit_cnt_nxt  = bit_cnt + 6'd1;
  assign slot_start   = sclk_fall && (bit_cnt_nxt[4:0] == 5'd0);
  assign pop          = slot_start && !fifo_empty;
  assign head_chan_ok = (fifo_head[AUD_WIDTH] == bit_cnt_nxt[5]);

  // Remember last cycle's enable to find its rising edge
  always_ff @(posedge aud_mclk or negedge aud_mresetn) begin
    if (!aud_mresetn) enable_d <= 1'b0;
    else              enable_d <= enable;
  end

  // FIFO pointers and occupancy; disabling the core drops everything buffered
  always_ff @(posedge aud_mclk or negedge aud_mresetn) begin
    if (!aud_mresetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (!enable) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // FIFO data array, written on accepted stream beats
  always_ff @(posedge aud_mclk) begin
    if (push) fifo_mem[wr_ptr] <= {s_axis_tid[0], s_axis_tdata[AUD_WIDTH+3:4]};
  end

  // SCLK generation: divisor latched at enable rise, 0 behaves like 1
  always_ff @(posedge aud_mclk or negedge aud_mresetn) begin
    if (!aud_mresetn) begin
      div_reg  <= 8'd1;
      div_cnt  <= 8'd0;
      sclk_out <= 1'b0;
    end else if (!enable) begin
      div_cnt  <= 8'd0;
      sclk_out <= 1'b0;
    end else if (!enable_d) begin
      div_reg  <= (sclk_div == 8'd0) ? 8'd1 : sclk_div;
      div_cnt  <= 8'd0;
      sclk_out <= 1'b0;
    end else if (div_tc) begin
      div_cnt  <= 8'd0;
      sclk_out <= ~sclk_out;
    end else begin
      div_cnt  <= div_cnt + 8'd1;
    end
  end

  // Frame sequencing on SCLK falling edges: slot loading, word select,
  // serial data and the underflow / channel-mismatch pulses
  always_ff @(posedge aud_mclk or negedge aud_mresetn) begin
    if (!aud_mresetn) begin
      bit_cnt   <= 6'd63;
      lrclk_out <= 1'b0;
      sdata_out <= 1'b0;
      shift_reg <= '0;
      underflow <= 1'b0;
      chan_err  <= 1'b0;
    end else if (!enable) begin
      bit_cnt   <= 6'd63;
      lrclk_out <= 1'b0;
      sdata_out <= 1'b0;
      shift_reg <= '0;
      underflow <= 1'b0;
      chan_err  <= 1'b0;
    end else begin
      underflow <= 1'b0;
      chan_err  <= 1'b0;
      if (sclk_fall) begin
        bit_cnt   <= bit_cnt_nxt;
        lrclk_out <= bit_cnt_nxt[5];
        if (slot_start) begin
          sdata_out <= 1'b0;
          if (fifo_empty) begin
            underflow <= 1'b1;
            shift_reg <= '0;
          end else if (!head_chan_ok) begin
            chan_err  <= 1'b1;
            shift_reg <= '0;
          end else begin
            shift_reg <= fifo_head[AUD_WIDTH-1:0];
          end
        end else if ({1'b0, bit_cnt_nxt[4:0]} <= LAST_DATA_POS) begin
          sdata_out <= shift_reg[AUD_WIDTH-1];
          shift_reg <= {shift_reg[AUD_WIDTH-2:0], 1'b0};
        end else begin
          sdata_out <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Self-checking bench for i2s_tx_serializer. A frame-level reference model
// derives every output from the number of mclk edges since enable rose and
// a queue of buffered samples; directed sequences and a table of divider
// settings exercise the corner cases, then randomized traffic runs.
module tb_i2s_tx_serializer;

  localparam int DEPTH = 4;

  logic        aud_mclk = 1'b0;
  logic        aud_mresetn;
  logic        enable;
  logic [7:0]  sclk_div;
  logic [31:0] s_axis_tdata;
  logic [2:0]  s_axis_tid;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        sclk_out;
  logic        lrclk_out;
  logic        sdata_out;
  logic        underflow;
  logic        chan_err;
  logic [2:0]  fifo_level;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  // Reference model state
  bit          m_prev_en = 1'b0;
  int          m_div     = 1;
  int          m_n       = 0;
  logic [24:0] mq[$];
  logic [23:0] m_sample  = '0;
  bit          e_sclk = 0, e_lr = 0, e_sd = 0, e_uf = 0, e_ce = 0;

  // Observation logs
  bit prev_sclk = 1'b0;
  int rise_cyc[$];
  bit sd_q[$];
  bit lr_q[$];
  int uf_cyc[$];
  bit uf_lr[$];
  int ce_cnt = 0;

  typedef struct {
    logic [7:0] div;
    int         exp_first;
    int         exp_period;
    int         exp_frame;
  } div_vec_t;

  div_vec_t vecs[5];

  i2s_tx_serializer dut (
    .aud_mclk      (aud_mclk),
    .aud_mresetn   (aud_mresetn),
    .enable        (enable),
    .sclk_div      (sclk_div),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tid    (s_axis_tid),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .sclk_out      (sclk_out),
    .lrclk_out     (lrclk_out),
    .sdata_out     (sdata_out),
    .underflow     (underflow),
    .chan_err      (chan_err),
    .fifo_level    (fifo_level)
  );

  // Free-running audio master clock
  always #5 aud_mclk = ~aud_mclk;

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, got, exp);
  endtask

  task automatic model_clear();
    mq.delete();
    m_prev_en = 1'b0;
    m_n       = 0;
    m_sample  = '0;
    {e_sclk, e_lr, e_sd, e_uf, e_ce} = '0;
  endtask

  // Advance the reference model by one mclk edge using the inputs that
  // were held across that edge
  task automatic model_edge();
    bit          en;
    bit          can_push;
    int          f, b, p;
    logic [24:0] e;
    en = enable && aud_mresetn;
    if (!en) begin
      model_clear();
      return;
    end
    can_push = (mq.size() < DEPTH);
    e_uf = 1'b0;
    e_ce = 1'b0;
    if (!m_prev_en) begin
      m_div  = (sclk_div == 8'd0) ? 1 : int'(sclk_div);
      m_n    = 0;
      e_sclk = 1'b0;
      e_lr   = 1'b0;
      e_sd   = 1'b0;
    end else begin
      m_n++;
      e_sclk = ((m_n / m_div) % 2) == 1;
      if ((m_n % (2 * m_div)) == 0) begin
        f    = m_n / (2 * m_div);
        b    = (f - 1) % 64;
        e_lr = (b >= 32);
        p    = b % 32;
        if (p == 0) begin
          e_sd = 1'b0;
          if (mq.size() == 0) begin
            e_uf     = 1'b1;
            m_sample = '0;
          end else begin
            e = mq.pop_front();
            if (e[24] != e_lr) begin
              e_ce     = 1'b1;
              m_sample = '0;
            end else begin
              m_sample = e[23:0];
            end
          end
        end else if (p <= 24) begin
          e_sd = m_sample[24 - p];
        end else begin
          e_sd = 1'b0;
        end
      end
    end
    if (can_push && s_axis_tvalid) mq.push_back({s_axis_tid[0], s_axis_tdata[27:4]});
    m_prev_en = 1'b1;
  endtask

  // One mclk cycle: check ready before the edge, then outputs after it
  task automatic applyStimulus();
    bit exp_ready;
    #1;
    exp_ready = enable && aud_mresetn && (mq.size() < DEPTH);
    check_val("tready", {31'd0, s_axis_tready}, {31'd0, exp_ready});
    @(posedge aud_mclk);
    #1;
    cyc++;
    model_edge();
    checkOutput();
    if (sclk_out && !prev_sclk) begin
      rise_cyc.push_back(cyc);
      sd_q.push_back(sdata_out);
      lr_q.push_back(lrclk_out);
    end
    prev_sclk = sclk_out;
    if (underflow) begin
      uf_cyc.push_back(cyc);
      uf_lr.push_back(lrclk_out);
    end
    if (chan_err) ce_cnt++;
  endtask

  task automatic checkOutput();
    logic [31:0] got, exp;
    got = {24'd0, sclk_out, lrclk_out, sdata_out, underflow, chan_err, fifo_level};
    exp = {24'd0, e_sclk, e_lr, e_sd, e_uf, e_ce, 3'(mq.size())};
    check_val("outputs{sclk,lr,sd,uf,ce,lvl}", got, exp);
  endtask

  task automatic clear_logs();
    rise_cyc.delete();
    sd_q.delete();
    lr_q.delete();
    uf_cyc.delete();
    uf_lr.delete();
    ce_cnt = 0;
  endtask

  task automatic check_all_zero(input string name);
    check_val(name, {25'd0, s_axis_tready, sclk_out, lrclk_out, sdata_out,
                     underflow, chan_err, fifo_level}, 32'd0);
  endtask

  // Main sequence
  initial begin
    int c0, waited;
    logic [23:0] word_l, word_r;
    int lr_ones_l, lr_ones_r;

    vecs[0] = '{8'd0, 1, 2, 128};
    vecs[1] = '{8'd1, 1, 2, 128};
    vecs[2] = '{8'd2, 2, 4, 256};
    vecs[3] = '{8'd4, 4, 8, 512};
    vecs[4] = '{8'd5, 5, 10, 640};

    aud_mresetn   = 1'b0;
    enable        = 1'b0;
    sclk_div      = 8'd1;
    s_axis_tdata  = '0;
    s_axis_tid    = '0;
    s_axis_tvalid = 1'b0;
    #2;
    check_all_zero("reset_outputs");
    applyStimulus();
    applyStimulus();
    aud_mresetn = 1'b1;
    applyStimulus();

    // Divider table: first rise, SCLK period and frame length with an
    // empty FIFO (one underflow per slot); sclk_div changes mid-run ignored
    foreach (vecs[i]) begin
      enable = 1'b0;
      applyStimulus();
      sclk_div = vecs[i].div;
      enable   = 1'b1;
      clear_logs();
      applyStimulus();
      c0       = cyc;
      sclk_div = 8'd3;
      for (int k = 0; k < 1000 && uf_cyc.size() < 3; k++) applyStimulus();
      if (uf_cyc.size() < 3 || rise_cyc.size() < 2) begin
        check_val("div_table_timeout", 32'd1, 32'd0);
      end else begin
        check_val("first_rise", 32'(rise_cyc[0] - c0), 32'(vecs[i].exp_first));
        check_val("sclk_period", 32'(rise_cyc[1] - rise_cyc[0]), 32'(vecs[i].exp_period));
        check_val("frame_len", 32'(uf_cyc[2] - uf_cyc[0]), 32'(vecs[i].exp_frame));
        check_val("uf_first_left", {31'd0, uf_lr[0]}, 32'd0);
      end
    end

    // Left/right sample pair with sclk_div=1
    enable = 1'b0;
    applyStimulus();
    sclk_div      = 8'd1;
    enable        = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'h0ABCDEF0;
    s_axis_tid    = 3'd0;
    clear_logs();
    applyStimulus();
    s_axis_tdata = 32'h01234560;
    s_axis_tid   = 3'd1;
    applyStimulus();
    s_axis_tvalid = 1'b0;
    for (int k = 0; k < 400 && rise_cyc.size() < 65; k++) applyStimulus();
    if (rise_cyc.size() < 65) begin
      check_val("lr_pair_timeout", 32'd1, 32'd0);
    end else begin
      word_l = '0;
      word_r = '0;
      lr_ones_l = 0;
      lr_ones_r = 0;
      for (int k = 0; k < 24; k++) begin
        word_l = {word_l[22:0], sd_q[2 + k]};
        word_r = {word_r[22:0], sd_q[34 + k]};
      end
      for (int k = 1; k <= 32; k++) lr_ones_l += int'(lr_q[k]);
      for (int k = 33; k <= 64; k++) lr_ones_r += int'(lr_q[k]);
      check_val("left_word", {8'd0, word_l}, 32'h00ABCDEF);
      check_val("right_word", {8'd0, word_r}, 32'h00123456);
      check_val("lrclk_left_slot", 32'(lr_ones_l), 32'd0);
      check_val("lrclk_right_slot", 32'(lr_ones_r), 32'd32);
      check_val("lr_pair_chan_err", 32'(ce_cnt), 32'd0);
    end

    // Five pushes with tvalid held: four fit, the fifth waits for a pop
    enable = 1'b0;
    applyStimulus();
    sclk_div      = 8'd8;
    enable        = 1'b1;
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bit acc;
      s_axis_tdata = $urandom;
      s_axis_tid   = 3'(k % 2);
      acc    = 1'b0;
      waited = 0;
      for (int t = 0; t < 100 && !acc; t++) begin
        acc = (mq.size() < DEPTH);
        applyStimulus();
        waited++;
      end
      check_val("push_accepted", {31'd0, acc}, 32'd1);
      if (k == 3) begin
        check_val("full_level", {29'd0, fifo_level}, 32'd4);
        check_val("full_tready", {31'd0, s_axis_tready}, 32'd0);
      end
      if (k == 4) begin
        check_val("fifth_waited", {31'd0, (waited > 1)}, 32'd1);
        check_val("after_fifth_level", {29'd0, fifo_level}, 32'd4);
      end
    end
    s_axis_tvalid = 1'b0;

    // First entry tagged right channel: discarded at the first left slot
    enable = 1'b0;
    applyStimulus();
    sclk_div      = 8'd1;
    enable        = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tid    = 3'd1;
    s_axis_tdata  = 32'h0FFFFFF0;
    applyStimulus();
    s_axis_tvalid = 1'b0;
    clear_logs();
    check_val("chan_level_before", {29'd0, fifo_level}, 32'd1);
    for (int k = 0; k < 20 && ce_cnt == 0; k++) applyStimulus();
    check_val("chan_err_seen", 32'(ce_cnt), 32'd1);
    check_val("chan_level_after", {29'd0, fifo_level}, 32'd0);
    check_val("chan_no_underflow", {31'd0, underflow}, 32'd0);

    // Disable in the middle of the left slot with three entries buffered
    enable = 1'b0;
    applyStimulus();
    sclk_div      = 8'd2;
    enable        = 1'b1;
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_axis_tdata = $urandom;
      s_axis_tid   = 3'(k % 2);
      applyStimulus();
    end
    s_axis_tvalid = 1'b0;
    for (int k = 0; k < 30 && fifo_level != 3'd3; k++) applyStimulus();
    for (int k = 0; k < 10; k++) applyStimulus();
    check_val("mid_slot_level", {29'd0, fifo_level}, 32'd3);
    enable = 1'b0;
    applyStimulus();
    check_all_zero("disable_flush");
    enable = 1'b1;
    clear_logs();
    applyStimulus();
    c0 = cyc;
    for (int k = 0; k < 50 && uf_cyc.size() == 0; k++) applyStimulus();
    if (uf_cyc.size() == 0) begin
      check_val("reenable_timeout", 32'd1, 32'd0);
    end else begin
      check_val("reenable_slot_start", 32'(uf_cyc[0] - c0), 32'd4);
      check_val("reenable_left", {31'd0, uf_lr[0]}, 32'd0);
    end

    // Randomized traffic with occasional enable drops, divider writes
    // while running, and one asynchronous reset in the middle of a frame
    for (int r = 0; r < 4; r++) begin
      enable = 1'b0;
      applyStimulus();
      sclk_div = 8'($urandom_range(0, 3));
      enable   = 1'b1;
      for (int i = 0; i < 400; i++) begin
        s_axis_tvalid = 1'($urandom_range(0, 1));
        s_axis_tdata  = $urandom;
        s_axis_tid    = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 149) == 0) sclk_div = 8'($urandom_range(0, 3));
        enable = ($urandom_range(0, 199) != 0);
        if (r == 2 && i == 200) begin
          aud_mresetn = 1'b0;
          #1;
          check_all_zero("async_reset");
          model_clear();
          applyStimulus();
          applyStimulus();
          aud_mresetn = 1'b1;
        end
        applyStimulus();
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/i2s_tx_serializer.md
I2S_TX_SERIALIZER -- requirements
Module: i2s_tx_serializer

Interface
REQ-001 Parameter AUD_WIDTH, default 24, audio sample width serialized per slot.
REQ-002 Parameter AXI_STREAM_DATA_WIDTH, default 32, stream data width.
REQ-003 Parameter AXI_STREAM_TID_WIDTH, default 3, stream TID width.
REQ-004 Parameter FIFO_DEPTH, default 4, sample buffer depth (power of two).
REQ-005 aud_mclk  in  1  sole clock; audio master clock; all logic on rising edge.
REQ-006 aud_mresetn  in  1  reset, asynchronous assert, active-low.
REQ-007 enable  in  1  core enable; 0 = idle and flush.
REQ-008 sclk_div  in  8  SCLK divider; SCLK period = 2*sclk_div mclk cycles; 0 treated as 1.
REQ-009 s_axis_tdata  in  32  audio subframe; sample in bits [27:4], MSB at bit 27.
REQ-010 s_axis_tid  in  3  bit 0 = channel (0 left, 1 right); bits [2:1] ignored.
REQ-011 s_axis_tvalid  in  1  stream valid.
REQ-012 s_axis_tready  out  1  stream ready.
REQ-013 sclk_out  out  1  I2S bit clock.
REQ-014 lrclk_out  out  1  I2S word select; 0 left, 1 right.
REQ-015 sdata_out  out  1  I2S serial data.
REQ-016 underflow  out  1  one-cycle pulse: slot started with FIFO empty.
REQ-017 chan_err  out  1  one-cycle pulse: FIFO head channel mismatched slot channel.
REQ-018 fifo_level  out  3  current FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-019 FIFO entry = {channel, tdata[27:4]}; push when s_axis_tvalid && s_axis_tready.
REQ-020 s_axis_tready = enable && (fifo_level < FIFO_DEPTH), combinational from registered level; no push at full even on a same-cycle pop.
REQ-021 Simultaneous push and pop: level unchanged; FIFO order preserved.
REQ-022 sclk_div captured into internal register on enable 0->1; changes while enabled ignored.
REQ-023 Divider counter counts mclk cycles 0..div-1; sclk_out toggles at terminal count; first rise div cycles after enable rise.
REQ-024 Bit counter bit_cnt (6 bits, 64 SCLK per frame) resets to 63; advances on each sclk_out falling edge (mclk cycle where sclk_out goes 1->0), wrapping 63->0.
REQ-025 lrclk_out = bit_cnt[5]; slot position p = bit_cnt[4:0]; sdata_out, lrclk_out change only with falling edges.
REQ-026 sdata_out: p=0 -> 0; p=1..24 -> sample bit (24-p), MSB first; p=25..31 -> 0.
REQ-027 Slot start (bit_cnt enters p=0): if FIFO non-empty, pop head in that mclk cycle into shift register.
REQ-028 Popped entry channel != bit_cnt[5]: entry discarded, slot transmits zeros, chan_err pulses same cycle.
REQ-029 FIFO empty at slot start: slot transmits zeros, underflow pulses same cycle; no pop.
REQ-030 enable 1->0: next cycle FIFO flushed (level 0), divider and bit_cnt to reset values, sclk_out/lrclk_out/sdata_out 0, tready 0; any in-progress slot aborted.
REQ-031 While enable=0, no pulses on underflow or chan_err.

Reset
REQ-032 On aud_mresetn low, immediately: s_axis_tready 0, sclk_out 0, lrclk_out 0, sdata_out 0, underflow 0, chan_err 0, fifo_level 0, bit_cnt 63, divider 0, FIFO empty.
REQ-033 Reset release followed by enable=1 starts per REQ-023; mid-frame reset discards all buffered samples.

Verification
REQ-034 sclk_div=1, enable, push L tdata=0x0ABCDEF0 tid=0, R 0x01234560 tid=1 -> sclk period 2 mclk; left slot p1..24 = 0xABCDEF MSB first, right slot = 0x123456, lrclk 0 for 32 SCLK then 1.
REQ-035 Push 5 samples with tvalid held, no frame running (enable just raised) -> 4 accepted, tready 0, fifo_level 4; 5th accepted after first pop.
REQ-036 Enable with FIFO empty -> underflow pulse at each slot start (every 32 SCLK), sdata_out constant 0.
REQ-037 First pushed entry tid=1 -> at first left slot chan_err pulse, zeros sent, entry consumed, fifo_level decrements.
REQ-038 sclk_div=0 vs 1 -> identical SCLK period (2 mclk); sclk_div=4 -> period 8 mclk, 512 mclk per frame.
REQ-039 Deassert enable mid-left-slot with 3 entries buffered -> next cycle fifo_level 0, all outputs 0; re-enable restarts at left slot p=0.
